// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_if
// Brief    : Groups the buart receive handshake and the iomem register-slot
//            signals seen by uart_rx_fifo. The master side (SoC / testbench)
//            drives the byte source and the bus; the slave side is the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if;
    // buart receive handshake
    logic        uart_valid;
    logic [7:0]  uart_data;
    logic        uart_rd;

    // iomem register slot
    logic        sel;
    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [1:0]  iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output uart_valid, uart_data,
        output sel, iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  uart_rd, iomem_rdata
    );

    modport slave (
        input  uart_valid, uart_data,
        input  sel, iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output uart_rd, iomem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Drains bytes from the buart receiver through its valid/rd
//            handshake into a 2^DEPTH_LOG2 entry FIFO, exposed to firmware as
//            four zero-wait-state iomem registers (DATA, STATUS, THRESH, CTRL).
//            Optional feature macro UART_RX_FIFO_IRQ_EN adds the THRESH
//            register and the registered irq output; without it THRESH reads
//            0 and irq is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic           clk,
    input  logic           resetq,
    uart_rx_fifo_if.slave  bus,
    output logic           irq
);

    localparam int c_DEPTH   = 1 << DEPTH_LOG2;
    localparam int c_PW      = DEPTH_LOG2 + 1;
    // Overflow sits at bit 8; only pushed up if the level field would reach it.
    localparam int c_OVF_BIT = (DEPTH_LOG2 > 4) ? (DEPTH_LOG2 + 4) : 8;

    localparam logic [1:0] c_REG_DATA   = 2'd0;
    localparam logic [1:0] c_REG_STATUS = 2'd1;
    localparam logic [1:0] c_REG_THRESH = 2'd2;
    localparam logic [1:0] c_REG_CTRL   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACK    = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_uart_rd;
    logic [c_PW-1:0]   r_wptr;
    logic [c_PW-1:0]   r_rptr;
    logic [7:0]        r_mem [c_DEPTH];
    logic              r_overflow;

    logic [c_PW-1:0]   w_level;
    logic              w_full;
    logic              w_empty;
    logic              w_rd_access;
    logic              w_wr_access;
    logic              w_pop;
    logic              w_ack;
    logic              w_push;
    logic              w_ovf_evt;
    logic              w_flush;
    logic              w_ovf_clr;
    logic [7:0]        w_thresh;
    logic [31:0]       w_status;
    logic [31:0]       w_rdata;
    logic              w_unused_ok;

    assign w_level = r_wptr - r_rptr;
    assign w_full  = (w_level == c_PW'(c_DEPTH));
    assign w_empty = (w_level == '0);

    // A read is any strobe with no byte enables; a write needs byte lane 0.
    assign w_rd_access = bus.sel && bus.iomem_valid && (bus.iomem_wstrb == 4'b0000);
    assign w_wr_access = bus.sel && bus.iomem_valid && bus.iomem_wstrb[0];

    assign w_pop     = w_rd_access && (bus.iomem_addr == c_REG_DATA) && !w_empty;
    assign w_ack     = (r_state == S_ACK);
    // A pop in the ACK cycle frees a slot, so a full FIFO still accepts the byte.
    assign w_push    = w_ack && (!w_full || w_pop);
    assign w_ovf_evt = w_ack && w_full && !w_pop;
    assign w_flush   = w_wr_access && (bus.iomem_addr == c_REG_CTRL) && bus.iomem_wdata[0];
    assign w_ovf_clr = w_wr_access && (bus.iomem_addr == c_REG_CTRL) && bus.iomem_wdata[1];

    assign w_unused_ok = ^bus.iomem_wdata;

    // Drain FSM: acknowledge one byte, then wait a cycle while buart drops valid.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_state   <= S_IDLE;
            r_uart_rd <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.uart_valid) begin
                        r_state   <= S_ACK;
                        r_uart_rd <= 1'b1;
                    end else begin
                        r_uart_rd <= 1'b0;
                    end
                end
                S_ACK: begin
                    r_state   <= S_SETTLE;
                    r_uart_rd <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_uart_rd <= 1'b0;
                end
            endcase
        end
    end

    assign bus.uart_rd = r_uart_rd;

    // FIFO pointers; a flush overrides any simultaneous push or pop.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (w_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push && !w_flush) begin
            r_mem[r_wptr[DEPTH_LOG2-1:0]] <= bus.uart_data;
        end
    end

    // Sticky overflow flag; a new overflow beats a clear in the same cycle.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_evt) begin
            r_overflow <= 1'b1;
        end else if (w_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_IRQ_EN
    logic [7:0] r_thresh;
    logic       r_irq;

    // Threshold register, written through byte lane 0.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_thresh <= 8'd1;
        end else if (w_wr_access && (bus.iomem_addr == c_REG_THRESH)) begin
            r_thresh <= bus.iomem_wdata[7:0];
        end
    end

    // Registered interrupt: overflow, or level at/above a non-zero threshold.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_overflow ||
                     ((r_thresh != 8'd0) && (32'(w_level) >= 32'(r_thresh)));
        end
    end

    assign w_thresh = r_thresh;
    assign irq      = r_irq;
`else
    assign w_thresh = 8'd0;
    assign irq      = 1'b0;
`endif

    // STATUS word: nonempty, full, level and overflow packed at fixed bits.
    always_comb begin
        w_status                = '0;
        w_status[0]             = !w_empty;
        w_status[2]             = w_full;
        w_status[3 +: c_PW]     = w_level;
        w_status[c_OVF_BIT]     = r_overflow;
    end

    // Zero-wait-state read mux; the slot returns 0 whenever it is not selected.
    always_comb begin
        w_rdata = '0;
        if (bus.sel) begin
            case (bus.iomem_addr)
                c_REG_DATA:   w_rdata = w_empty ? 32'd0
                                                : {24'd0, r_mem[r_rptr[DEPTH_LOG2-1:0]]};
                c_REG_STATUS: w_rdata = w_status;
                c_REG_THRESH: w_rdata = {24'd0, w_thresh};
                default:      w_rdata = '0;
            endcase
        end
    end

    assign bus.iomem_rdata = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Self-checking bench for uart_rx_fifo. A queue-based model of the
//            FIFO, overflow flag, threshold and interrupt predicts every
//            register read, uart_rd and irq, under directed and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetq = 1'b0;
    logic irq;

    uart_rx_fifo_if bus();

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk    (clk),
        .resetq (resetq),
        .bus    (bus),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] tx_q[$];
    bit         m_ovf;
    logic [7:0] m_thresh;
    bit         m_irq;
    int         m_phase;   // 0 waiting for byte, 1 acknowledging, 2 settling

    int n_vec = 0;
    int n_err = 0;

    function automatic void model_reset();
        m_q.delete();
        m_ovf    = 1'b0;
        m_thresh = 8'd1;
        m_irq    = 1'b0;
        m_phase  = 0;
    endfunction

    function automatic logic [31:0] model_rdata();
        logic [31:0] r;
        r = 32'd0;
        if (bus.sel) begin
            case (bus.iomem_addr)
                2'd0: r = (m_q.size() != 0) ? {24'd0, m_q[0]} : 32'd0;
                2'd1: begin
                    r = (32'(m_ovf) << 8) | (32'(m_q.size()) << 3);
                    if (m_q.size() == DEPTH) r = r | 32'd4;
                    if (m_q.size() != 0)     r = r | 32'd1;
                end
                2'd2: r = IRQ_EN ? {24'd0, m_thresh} : 32'd0;
                default: r = 32'd0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [33:0] exp_vec();
        return {(m_phase == 1), m_irq, model_rdata()};
    endfunction

    task automatic bus_set(input logic s, input logic v, input logic [3:0] st,
                           input logic [1:0] a, input logic [31:0] d);
        bus.sel         = s;
        bus.iomem_valid = v;
        bus.iomem_wstrb = st;
        bus.iomem_addr  = a;
        bus.iomem_wdata = d;
    endtask

    task automatic send(input logic [7:0] b);
        tx_q.push_back(b);
        bus.uart_valid = 1'b1;
        bus.uart_data  = tx_q[0];
    endtask

    // One clock edge: advance the model from the inputs seen at that edge.
    task automatic tick();
        int  lvl;
        bit  rd_now, pop, wr, fl, clr, ovf_evt, irq_next;
        @(posedge clk);
        rd_now   = (m_phase == 1);
        lvl      = m_q.size();
        irq_next = IRQ_EN && (m_ovf || (m_thresh != 0 && lvl >= int'(m_thresh)));
        pop = bus.sel && bus.iomem_valid && (bus.iomem_wstrb == 4'd0) &&
              (bus.iomem_addr == 2'd0) && (lvl > 0);
        wr  = bus.sel && bus.iomem_valid && bus.iomem_wstrb[0];
        fl  = wr && (bus.iomem_addr == 2'd3) && bus.iomem_wdata[0];
        clr = wr && (bus.iomem_addr == 2'd3) && bus.iomem_wdata[1];
        ovf_evt = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (rd_now) begin
            if (m_q.size() < DEPTH) m_q.push_back(bus.uart_data);
            else ovf_evt = 1'b1;
        end
        if (fl) m_q.delete();
        if (ovf_evt) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (IRQ_EN && wr && bus.iomem_addr == 2'd2) m_thresh = bus.iomem_wdata[7:0];
        m_irq = irq_next;
        case (m_phase)
            0:       if (bus.uart_valid) m_phase = 1;
            1:       m_phase = 2;
            default: m_phase = 0;
        endcase
        if (rd_now && tx_q.size() != 0) void'(tx_q.pop_front());
        #1;
        bus.uart_valid = (tx_q.size() != 0);
        if (tx_q.size() != 0) bus.uart_data = tx_q[0];
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while ((tx_q.size() != 0 || m_phase != 0) && k < 120) begin
            #1; n_vec++;
            if ({bus.uart_rd, irq, bus.iomem_rdata} !== exp_vec()) begin
                n_err++;
                $display("FAIL %s drain: got %h want %h", tag,
                         {bus.uart_rd, irq, bus.iomem_rdata}, exp_vec());
            end
            tick();
            k++;
        end
        n_vec++;
        if (k >= 120) begin
            n_err++;
            $display("FAIL %s drain timeout: got %0d pending want 0", tag, tx_q.size());
        end
    endtask

    task automatic clean_start();
        bus_set(1'b1, 1'b1, 4'hF, 2'd3, 32'd3);
        tick();
        bus_set(1'b1, 1'b0, 4'h0, 2'd1, 32'd0);
        tick();
    endtask

    task automatic test_reset();
        bus_set(1'b0, 1'b0, 4'h0, 2'd0, 32'd0);
        bus.uart_valid = 1'b0;
        bus.uart_data  = 8'd0;
        resetq = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2; n_vec++;
        if ({bus.uart_rd, irq, bus.iomem_rdata} !== 34'd0) begin
            n_err++;
            $display("FAIL reset idle: got %h want 0", {bus.uart_rd, irq, bus.iomem_rdata});
        end
        bus_set(1'b1, 1'b0, 4'h0, 2'd1, 32'd0);
        #1; n_vec++;
        if (bus.iomem_rdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset status: got %h want 0", bus.iomem_rdata);
        end
        bus_set(1'b1, 1'b0, 4'h0, 2'd2, 32'd0);
        #1; n_vec++;
        if (bus.iomem_rdata !== (IRQ_EN ? 32'd1 : 32'd0)) begin
            n_err++;
            $display("FAIL reset thresh: got %h want %h", bus.iomem_rdata, IRQ_EN ? 32'd1 : 32'd0);
        end
        @(posedge clk);
        #1 resetq = 1'b1;
    endtask

    task automatic test_single();
        bus_set(1'b1, 1'b0, 4'h0, 2'd1, 32'd0);
        send(8'h41);
        #1; n_vec++;
        if (bus.uart_rd !== 1'b0 || bus.iomem_rdata !== 32'd0) begin
            n_err++;
            $display("FAIL single pre: got rd=%b st=%h want rd=0 st=0", bus.uart_rd, bus.iomem_rdata);
        end
        tick();
        #1; n_vec++;
        if (bus.uart_rd !== 1'b1) begin
            n_err++;
            $display("FAIL single rd_pulse: got %b want 1", bus.uart_rd);
        end
        tick();
        #1; n_vec++;
        if (bus.uart_rd !== 1'b0 || bus.iomem_rdata !== 32'h009) begin
            n_err++;
            $display("FAIL single stored: got rd=%b st=%h want rd=0 st=009", bus.uart_rd, bus.iomem_rdata);
        end
        bus_set(1'b1, 1'b1, 4'h0, 2'd0, 32'd0);
        #1; n_vec++;
        if (bus.iomem_rdata !== 32'h41) begin
            n_err++;
            $display("FAIL single data: got %h want 41", bus.iomem_rdata);
        end
        tick();
        bus_set(1'b1, 1'b0, 4'h0, 2'd1, 32'd0);
        #1; n_vec++;
        if (bus.iomem_rdata !== 32'h000) begin
            n_err++;
            $display("FAIL single empty: got %h want 000", bus.iomem_rdata);
        end
        wait_drain("single");
        repeat (2) tick();
    endtask

    task automatic test_overflow();
        int rd_pulses;
        clean_start();
        for (int i = 0; i < 16; i++) send(8'(i));
        send(8'hFF);
        rd_pulses = 0;
        for (int i = 0; i < 56; i++) begin
            #1; n_vec++;
            if ({bus.uart_rd, irq, bus.iomem_rdata} !== exp_vec()) begin
                n_err++;
                $display("FAIL overflow fill c%0d: got %h want %h", i,
                         {bus.uart_rd, irq, bus.iomem_rdata}, exp_vec());
            end
            if (bus.uart_rd === 1'b1) rd_pulses++;
            tick();
        end
        wait_drain("overflow");
        #1; n_vec++;
        if (rd_pulses !== 17 || bus.iomem_rdata !== 32'h185) begin
            n_err++;
            $display("FAIL overflow status: got pulses=%0d st=%h want 17 185", rd_pulses, bus.iomem_rdata);
        end
        for (int i = 0; i < 17; i++) begin
            bus_set(1'b1, 1'b1, 4'h0, 2'd0, 32'd0);
            #1; n_vec++;
            if (bus.iomem_rdata !== ((i < 16) ? 32'(i) : 32'd0)) begin
                n_err++;
                $display("FAIL overflow read%0d: got %h want %h", i, bus.iomem_rdata,
                         (i < 16) ? 32'(i) : 32'd0);
            end
            tick();
        end
        bus_set(1'b1, 1'b0, 4'h0, 2'd1, 32'd0);
        #1; n_vec++;
        if (bus.iomem_rdata !== 32'h100 || irq !== IRQ_EN) begin
            n_err++;
            $display("FAIL overflow sticky: got st=%h irq=%b want 100 %b", bus.iomem_rdata, irq, IRQ_EN);
        end
        tick();
    endtask

    task automatic test_full_pop_ack();
        logic [31:0] last;
        int k;
        clean_start();
        for (int i = 0; i < 16; i++) send(8'($urandom_range(0, 255)));
        wait_drain("fullpop");
        send(8'h55);
        k = 0;
        while (m_phase != 1 && k < 8) begin
            #1; n_vec++;
            if ({bus.uart_rd, irq, bus.iomem_rdata} !== exp_vec()) begin
                n_err++;
                $display("FAIL fullpop wait: got %h want %h", {bus.uart_rd, irq, bus.iomem_rdata}, exp_vec());
            end
            tick();
            k++;
        end
        bus_set(1'b1, 1'b1, 4'h0, 2'd0, 32'd0);
        #1; n_vec++;
        if ({bus.uart_rd, irq, bus.iomem_rdata} !== exp_vec()) begin
            n_err++;
            $display("FAIL fullpop ackread: got %h want %h", {bus.uart_rd, irq, bus.iomem_rdata}, exp_vec());
        end
        tick();
        bus_set(1'b1, 1'b0, 4'h0, 2'd1, 32'd0);
        #1; n_vec++;
        if (bus.iomem_rdata !== 32'h085) begin
            n_err++;
            $display("FAIL fullpop status: got %h want 085", bus.iomem_rdata);
        end
        last = 32'd0;
        for (int i = 0; i < 16; i++) begin
            bus_set(1'b1, 1'b1, 4'h0, 2'd0, 32'd0);
            #1; n_vec++;
            if (bus.iomem_rdata !== model_rdata()) begin
                n_err++;
                $display("FAIL fullpop read%0d: got %h want %h", i, bus.iomem_rdata, model_rdata());
            end
            last = bus.iomem_rdata;
            tick();
        end
        n_vec++;
        if (last !== 32'h55) begin
            n_err++;
            $display("FAIL fullpop last: got %h want 55", last);
        end
        wait_drain("fullpop2");
    endtask

    task automatic test_irq();
        clean_start();
        bus_set(1'b1, 1'b1, 4'hF, 2'd2, 32'd3);
        tick();
        bus_set(1'b1, 1'b0, 4'h0, 2'd2, 32'd0);
        #1; n_vec++;
        if (bus.iomem_rdata !== (IRQ_EN ? 32'd3 : 32'd0)) begin
            n_err++;
            $display("FAIL irq thresh: got %h want %h", bus.iomem_rdata, IRQ_EN ? 32'd3 : 32'd0);
        end
        send(8'h01);
        send(8'h02);
        wait_drain("irq2");
        repeat (2) tick();
        #1; n_vec++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq below: got %b want 0", irq);
        end
        send(8'h03);
        for (int i = 0; i < 5; i++) begin
            #1; n_vec++;
            if ({bus.uart_rd, irq, bus.iomem_rdata} !== exp_vec()) begin
                n_err++;
                $display("FAIL irq rise c%0d: got %h want %h", i, {bus.uart_rd, irq, bus.iomem_rdata}, exp_vec());
            end
            tick();
        end
        #1; n_vec++;
        if (irq !== IRQ_EN) begin
            n_err++;
            $display("FAIL irq at3: got %b want %b", irq, IRQ_EN);
        end
        bus_set(1'b1, 1'b1, 4'h0, 2'd0, 32'd0);
        tick();
        bus_set(1'b0, 1'b0, 4'h0, 2'd0, 32'd0);
        tick();
        #1; n_vec++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq fall: got %b want 0", irq);
        end
    endtask

    task automatic test_flush();
        int k;
        clean_start();
        bus_set(1'b1, 1'b1, 4'h1, 2'd2, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i));
        wait_drain("flush");
        send(8'h77);
        k = 0;
        while (m_phase != 1 && k < 8) begin
            tick();
            k++;
        end
        bus_set(1'b1, 1'b1, 4'h1, 2'd3, 32'd1);
        #1; n_vec++;
        if (bus.uart_rd !== 1'b1) begin
            n_err++;
            $display("FAIL flush ack: got %b want 1", bus.uart_rd);
        end
        tick();
        bus_set(1'b1, 1'b0, 4'h0, 2'd1, 32'd0);
        #1; n_vec++;
        if (bus.iomem_rdata !== 32'h000) begin
            n_err++;
            $display("FAIL flush level: got %h want 000", bus.iomem_rdata);
        end
        wait_drain("flush2");
        for (int i = 0; i < 17; i++) send(8'(i * 3));
        wait_drain("flush3");
        tick();
        #1; n_vec++;
        if (bus.iomem_rdata !== 32'h185 || irq !== IRQ_EN) begin
            n_err++;
            $display("FAIL flush ovf: got st=%h irq=%b want 185 %b", bus.iomem_rdata, irq, IRQ_EN);
        end
        bus_set(1'b1, 1'b1, 4'h1, 2'd3, 32'd2);
        tick();
        bus_set(1'b1, 1'b0, 4'h0, 2'd1, 32'd0);
        #1; n_vec++;
        if (bus.iomem_rdata !== 32'h085) begin
            n_err++;
            $display("FAIL ovf clear: got %h want 085", bus.iomem_rdata);
        end
        tick();
        #1; n_vec++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL ovf irq drop: got %b want 0", irq);
        end
    endtask

    task automatic test_reset_mid_ack();
        int k;
        clean_start();
        send(8'h3C);
        k = 0;
        while (m_phase != 1 && k < 8) begin
            tick();
            k++;
        end
        #1 resetq = 1'b0;
        tx_q.delete();
        bus.uart_valid = 1'b0;
        model_reset();
        #1; n_vec++;
        if (bus.uart_rd !== 1'b0) begin
            n_err++;
            $display("FAIL reset ack rd: got %b want 0", bus.uart_rd);
        end
        @(posedge clk);
        #1 resetq = 1'b1;
        #1; n_vec++;
        if (bus.iomem_rdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset ack status: got %h want 0", bus.iomem_rdata);
        end
        bus_set(1'b1, 1'b0, 4'h0, 2'd2, 32'd0);
        #1; n_vec++;
        if (bus.iomem_rdata !== (IRQ_EN ? 32'd1 : 32'd0)) begin
            n_err++;
            $display("FAIL reset ack thresh: got %h want %h", bus.iomem_rdata, IRQ_EN ? 32'd1 : 32'd0);
        end
        tick();
    endtask

    task automatic test_random();
        int op;
        logic s;
        for (int i = 0; i < 600; i++) begin
            if (tx_q.size() < 2 && $urandom_range(0, 2) == 0) send(8'($urandom_range(0, 255)));
            op = $urandom_range(0, 19);
            s  = ($urandom_range(0, 7) != 0);
            if (op < 6)       bus_set(s, 1'b0, 4'h0, 2'($urandom_range(0, 3)), 32'd0);
            else if (op < 11) bus_set(s, 1'b1, 4'h0, 2'd0, 32'd0);
            else if (op == 11) bus_set(s, 1'b1, 4'h0, 2'd2, 32'd0);
            else if (op == 12) bus_set(s, 1'b1, 4'h1, 2'd2, 32'($urandom_range(0, 18)));
            else if (op == 13) bus_set(s, 1'b1, 4'hF, 2'd3,
                                       ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : 32'd0);
            else if (op == 14) bus_set(s, 1'b1, 4'hE, 2'($urandom_range(0, 3)), 32'hFFFF_FFFF);
            else if (op == 15) bus_set(s, 1'b1, 4'hF, 2'($urandom_range(0, 1)), 32'hFFFF_FFFF);
            else              bus_set(s, 1'b1, 4'h0, 2'd1, 32'd0);
            #1; n_vec++;
            if ({bus.uart_rd, irq, bus.iomem_rdata} !== exp_vec()) begin
                n_err++;
                $display("FAIL random c%0d: got %h want %h", i, {bus.uart_rd, irq, bus.iomem_rdata}, exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_pop_ack();
        test_irq();
        test_flush();
        test_reset_mid_ack();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer between the `buart` receiver and the iomem register bus of the icebreaker SoC. It drains received bytes from `buart` through its valid/rd handshake into a parameterised FIFO. Firmware reads those bytes, plus status, threshold and control registers, through one iomem address-decoded slot with zero wait states. A registered interrupt can feed a free picosoc IRQ line (`irq_6`).

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 bytes (16).

Ports:
- `clk` in 1: system clock, 12 MHz.
- `resetq` in 1: reset; asynchronous, active-low.
- `uart_valid` in 1: `buart` has a received byte.
- `uart_data` in 8: `buart` received byte.
- `uart_rd` out 1: one-cycle acknowledge to `buart` (its `rd` input).
- `sel` in 1: iomem slot select (decoded address bit, e.g. `iomem_addr[20]`).
- `iomem_valid` in 1: bus access strobe. The top-level `iomem_ready` remains equal to `iomem_valid`.
- `iomem_wstrb` in 4: byte write strobes; all zero means read.
- `iomem_addr` in 2: register select, driven from bus `addr[3:2]`.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: read data; 0 when `sel` is low.
- `irq` out 1: registered interrupt request.

## Operation
- Registers, selected by `iomem_addr`:
  - 0 DATA (read only): `{24'b0, head}`. A read pops one entry. Reading while empty returns 0 and pops nothing.
  - 1 STATUS (read only): `{…0, overflow[8], level[DEPTH_LOG2+1+2:3], full[2], 0, nonempty[0]}`, with level starting at bit 3.
  - 2 THRESH (read/write, byte 0): interrupt level threshold; reset value 1.
  - 3 CTRL (write only, reads 0): bit0 flushes the FIFO; bit1 clears overflow.
- A write requires `iomem_wstrb[0]`. Writes to DATA or STATUS are ignored.
- FIFO storage: write/read pointers of width DEPTH_LOG2+1. Level = wptr − rptr, modulo 2^(DEPTH_LOG2+1). Pointers wrap naturally.
  - full: level == 2^DEPTH_LOG2.
  - empty: level == 0.
- Drain FSM states:
  - IDLE: if `uart_valid`, go to ACK.
  - ACK: `uart_rd` = 1 for this single cycle. At the clock edge, if not full, write `uart_data` and increment wptr. If full, drop the byte and set overflow. Go to SETTLE.
  - SETTLE: ignore `uart_valid` for one cycle while `buart` clears it. Go to IDLE.
- Simultaneous push and pop: both take effect; level is unchanged. The popped value is the old head. When the FIFO is full, a pop in the same cycle as ACK frees space first, so the push succeeds with no overflow.
- Flush together with a push or pop: flush wins. Both pointers go to 0 and the pushed byte is discarded. `uart_rd` is still asserted.
- Flush together with an overflow event: overflow is still set.
- Overflow-clear together with a new overflow event: set wins.
- irq is registered: `irq <= overflow | (thresh != 0 && level >= thresh)`.

## Timing
- Reset values: `uart_rd` = 0, `irq` = 0, `iomem_rdata` = 0 when `sel` is low, pointers = 0, overflow = 0, thresh = 1, state = IDLE.
- Reset asserted mid-operation aborts any ACK. `uart_rd` drops immediately.
- `uart_valid` sampled high at edge N: `uart_rd` is high during cycle N+1, the byte is stored at edge N+2, and nonempty reads 1 from cycle N+2.
- `irq` rises at edge N+3.
- Sustained rate: one byte per 3 cycles, far above 115200 baud.
- `iomem_rdata` is combinational from `sel`, `iomem_addr` and current state. It is valid in the same cycle as `iomem_valid`.
- The pop takes effect at the end of that cycle. A back-to-back DATA read in the next cycle returns the next entry.
- Register writes take effect at the edge that ends the access cycle.

## Configuration
- `UART_RX_FIFO_IRQ_EN`:
  - Defined: THRESH register and `irq` logic are present as described.
  - Undefined: no THRESH storage. THRESH reads 0 and writes are ignored; `irq` is tied to 0. The FIFO, overflow flag and STATUS are unchanged.

## Test plan
- Reset, then pulse `uart_valid` with `uart_data`=0x41 → `uart_rd` is one cycle high at N+1, STATUS=0x009 at N+2, DATA read returns 0x41, then STATUS=0x000.
- Push 16 bytes 0x00..0x0F, then a 17th byte 0xFF → `uart_rd` is still pulsed, full=1, overflow=1 (STATUS bit8), level=16. Sixteen DATA reads return 0x00..0x0F in order. A 17th read returns 0.
- FIFO full at level 16; DATA read in the same cycle as ACK for 0x55 → no overflow, level stays 16, the last entry read out is 0x55.
- THRESH=3 (IRQ_EN defined): push 2 bytes → `irq`=0. Third byte → `irq`=1 at N+3. One DATA read → `irq`=0 one cycle later.
- Write CTRL=0x1 in the same cycle as an ACK → level=0, byte discarded. Write CTRL=0x2 → overflow clears and `irq` drops.
- Assert `resetq` low during ACK → `uart_rd`=0 immediately, STATUS=0 and THRESH=1 after release. Without `UART_RX_FIFO_IRQ_EN`: THRESH reads 0 and `irq` stays 0 through an overflow.
